// File: rtl/if_id_reg_pkg.sv
// Shared constants for the IF/ID pipeline register: stall bus layout,
// stall polarity, IF->ID bus width and the NOP encoding.
package if_id_reg_pkg;

  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int IF_TO_ID_WD = 33;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg_inst_hold_buf.sv
// Captures the instruction SRAM word on the first fully-stalled edge and
// keeps presenting it until released, since the SRAM address moves on.
module inst_hold_buf #(
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture,
  input  logic [INST_W-1:0] rdata,
  output logic [INST_W-1:0] inst,
  output logic              hold_valid
);

  logic [INST_W-1:0] inst_hold;

  // Only the first capture is kept; later SRAM data belongs to a newer PC.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      inst_hold  <= '0;
      hold_valid <= 1'b0;
    end else if (capture && !hold_valid) begin
      inst_hold  <= rdata;
      hold_valid <= 1'b1;
    end
  end

  assign inst = hold_valid ? inst_hold : rdata;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: registers IF's {ce, pc}, aligns it with the
// 1-cycle-latency SRAM data, inserts bubbles on stall boundaries, clears on flush.
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INST_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [PC_W:0]      if_to_id_bus,
  input  logic [INST_W-1:0]  inst_sram_rdata,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc,
  output logic [INST_W-1:0]  id_inst,
  output logic               hold_active
);

  logic              if_ce;
  logic [PC_W-1:0]   if_pc;
  logic              stall_if;
  logic              stall_id;
  logic              valid_r;
  logic [PC_W-1:0]   pc_r;
  logic              buf_clear;
  logic              buf_capture;
  logic [INST_W-1:0] buf_inst;
  logic              hold_valid;
  logic              unused_stall;

  assign if_ce    = if_to_id_bus[PC_W];
  assign if_pc    = if_to_id_bus[PC_W-1:0];
  assign stall_if = stall[STALL_IF];
  assign stall_id = stall[STALL_ID];

  assign unused_stall = ^{stall[STALL_W-1:STALL_ID+1], stall[0]};

  // Stall[1]=0 with stall[2]=1 is not legal upstream; it falls into advance.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_r <= 1'b0;
      pc_r    <= '0;
    end else if (stall_if == NO_STOP) begin
      valid_r <= if_ce;
      pc_r    <= if_pc;
    end else if (stall_id == NO_STOP) begin
      valid_r <= 1'b0;
      pc_r    <= '0;
    end
  end

  assign buf_clear   = flush || (stall_if == NO_STOP) || (stall_id == NO_STOP);
  assign buf_capture = (stall_if == STOP) && (stall_id == STOP);

  inst_hold_buf #(
    .INST_W(INST_W)
  ) u_inst_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (buf_clear),
    .capture   (buf_capture),
    .rdata     (inst_sram_rdata),
    .inst      (buf_inst),
    .hold_valid(hold_valid)
  );

  assign id_inst     = valid_r ? buf_inst : INST_W'(NOP_INST);
  assign id_valid    = valid_r;
  assign id_pc       = pc_r;
  assign hold_active = hold_valid;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg: reset, advance, ID/IF stalls,
// flush during a stall and reset during a stall.
module tb_if_id_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [32:0] if_to_id_bus;
  logic [31:0] inst_sram_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        hold_active;

  int checks;
  int errors;

  if_id_reg #(
    .PC_W   (32),
    .INST_W (32),
    .STALL_W(6)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .if_to_id_bus   (if_to_id_bus),
    .inst_sram_rdata(inst_sram_rdata),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .hold_active    (hold_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the IF-side inputs for the upcoming edge.
  task automatic applyStimulus(input logic ce, input logic [31:0] pc,
                               input logic [5:0] stl, input logic fl);
    if_to_id_bus = {ce, pc};
    stall        = stl;
    flush        = fl;
  endtask

  // Advances one edge, then presents the SRAM word for the cycle just entered.
  task automatic tick(input logic [31:0] rdata);
    @(posedge clk);
    #1;
    inst_sram_rdata = rdata;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 6'b0, 1'b0);
    tick(32'hDEADBEEF);
    checks += 4;
    if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", id_valid); end
    if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h want 0", id_pc); end
    if (id_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst got %h want 0", id_inst); end
    if (hold_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold got %0b want 0", hold_active); end
    rst = 1'b0;
  endtask

  task automatic test_advance;
    applyStimulus(1'b1, 32'hBFC00000, 6'b0, 1'b0);
    tick(32'h3C08BFC0);
    checks += 3;
    if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL adv0_valid got %0b want 1", id_valid); end
    if (id_pc !== 32'hBFC00000) begin errors++; $display("[TB] FAIL adv0_pc got %h want bfc00000", id_pc); end
    if (id_inst !== 32'h3C08BFC0) begin errors++; $display("[TB] FAIL adv0_inst got %h want 3c08bfc0", id_inst); end
    applyStimulus(1'b1, 32'hBFC00004, 6'b0, 1'b0);
    tick(32'h35080010);
    checks += 3;
    if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL adv1_valid got %0b want 1", id_valid); end
    if (id_pc !== 32'hBFC00004) begin errors++; $display("[TB] FAIL adv1_pc got %h want bfc00004", id_pc); end
    if (id_inst !== 32'h35080010) begin errors++; $display("[TB] FAIL adv1_inst got %h want 35080010", id_inst); end
  endtask

  task automatic test_ce_zero;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 6'b0, 1'b0);
    tick(32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'hBFBFFFFC, 6'b0, 1'b0);
    tick(32'hDEADBEEF);
    checks += 3;
    if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL ce0_valid got %0b want 0", id_valid); end
    if (id_inst !== 32'h0) begin errors++; $display("[TB] FAIL ce0_inst got %h want 0", id_inst); end
    if (id_pc !== 32'hBFBFFFFC) begin errors++; $display("[TB] FAIL ce0_pc got %h want bfbffffc", id_pc); end
  endtask

  task automatic test_id_stall;
    applyStimulus(1'b1, 32'h80000010, 6'b0, 1'b0);
    tick(32'h8C220004);
    checks += 1;
    if (id_inst !== 32'h8C220004) begin errors++; $display("[TB] FAIL ids_pre_inst got %h want 8c220004", id_inst); end
    applyStimulus(1'b1, 32'h80000014, 6'b000111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(32'h00000000);
      checks += 4;
      if (id_inst !== 32'h8C220004) begin errors++; $display("[TB] FAIL ids_inst[%0d] got %h want 8c220004", i, id_inst); end
      if (hold_active !== 1'b1) begin errors++; $display("[TB] FAIL ids_hold[%0d] got %0b want 1", i, hold_active); end
      if (id_pc !== 32'h80000010) begin errors++; $display("[TB] FAIL ids_pc[%0d] got %h want 80000010", i, id_pc); end
      if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL ids_valid[%0d] got %0b want 1", i, id_valid); end
    end
    applyStimulus(1'b1, 32'h80000014, 6'b0, 1'b0);
    tick(32'h24420001);
    checks += 3;
    if (id_pc !== 32'h80000014) begin errors++; $display("[TB] FAIL ids_rel_pc got %h want 80000014", id_pc); end
    if (id_inst !== 32'h24420001) begin errors++; $display("[TB] FAIL ids_rel_inst got %h want 24420001", id_inst); end
    if (hold_active !== 1'b0) begin errors++; $display("[TB] FAIL ids_rel_hold got %0b want 0", hold_active); end
  endtask

  task automatic test_if_stall;
    applyStimulus(1'b1, 32'h80000018, 6'b000011, 1'b0);
    tick(32'h8C230008);
    checks += 4;
    if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL ifs_valid got %0b want 0", id_valid); end
    if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL ifs_pc got %h want 0", id_pc); end
    if (id_inst !== 32'h0) begin errors++; $display("[TB] FAIL ifs_inst got %h want 0", id_inst); end
    if (hold_active !== 1'b0) begin errors++; $display("[TB] FAIL ifs_hold got %0b want 0", hold_active); end
    applyStimulus(1'b1, 32'h80000018, 6'b0, 1'b0);
    tick(32'hAC430000);
    checks += 3;
    if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL ifs_rel_valid got %0b want 1", id_valid); end
    if (id_pc !== 32'h80000018) begin errors++; $display("[TB] FAIL ifs_rel_pc got %h want 80000018", id_pc); end
    if (id_inst !== 32'hAC430000) begin errors++; $display("[TB] FAIL ifs_rel_inst got %h want ac430000", id_inst); end
    applyStimulus(1'b1, 32'h8000001C, 6'b0, 1'b0);
    tick(32'h2402000A);
    checks += 2;
    if (id_pc !== 32'h8000001C) begin errors++; $display("[TB] FAIL ifs_next_pc got %h want 8000001c", id_pc); end
    if (id_inst !== 32'h2402000A) begin errors++; $display("[TB] FAIL ifs_next_inst got %h want 2402000a", id_inst); end
  endtask

  task automatic test_flush_mid_stall;
    applyStimulus(1'b1, 32'h80000020, 6'b000111, 1'b0);
    tick(32'h11111111);
    checks += 2;
    if (hold_active !== 1'b1) begin errors++; $display("[TB] FAIL fl_pre_hold got %0b want 1", hold_active); end
    if (id_inst !== 32'h2402000A) begin errors++; $display("[TB] FAIL fl_pre_inst got %h want 2402000a", id_inst); end
    applyStimulus(1'b1, 32'h80000020, 6'b000111, 1'b1);
    tick(32'hDEADBEEF);
    checks += 4;
    if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_valid got %0b want 0", id_valid); end
    if (hold_active !== 1'b0) begin errors++; $display("[TB] FAIL fl_hold got %0b want 0", hold_active); end
    if (id_inst !== 32'h0) begin errors++; $display("[TB] FAIL fl_inst got %h want 0", id_inst); end
    if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL fl_pc got %h want 0", id_pc); end
    applyStimulus(1'b1, 32'h80000020, 6'b000111, 1'b0);
    tick(32'hDEADBEEF);
    checks += 1;
    if (id_inst !== 32'h0) begin errors++; $display("[TB] FAIL fl_stall_inst got %h want 0", id_inst); end
    applyStimulus(1'b1, 32'hBFC00380, 6'b0, 1'b0);
    tick(32'h401A6800);
    checks += 4;
    if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL fl_rel_valid got %0b want 1", id_valid); end
    if (id_pc !== 32'hBFC00380) begin errors++; $display("[TB] FAIL fl_rel_pc got %h want bfc00380", id_pc); end
    if (id_inst !== 32'h401A6800) begin errors++; $display("[TB] FAIL fl_rel_inst got %h want 401a6800", id_inst); end
    if (hold_active !== 1'b0) begin errors++; $display("[TB] FAIL fl_rel_hold got %0b want 0", hold_active); end
  endtask

  task automatic test_reset_mid_stall;
    applyStimulus(1'b1, 32'hBFC00384, 6'b000111, 1'b0);
    tick(32'h00000000);
    checks += 2;
    if (hold_active !== 1'b1) begin errors++; $display("[TB] FAIL rs_pre_hold got %0b want 1", hold_active); end
    if (id_inst !== 32'h401A6800) begin errors++; $display("[TB] FAIL rs_pre_inst got %h want 401a6800", id_inst); end
    rst = 1'b1;
    tick(32'h12345678);
    rst = 1'b0;
    checks += 4;
    if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rs_valid got %0b want 0", id_valid); end
    if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL rs_pc got %h want 0", id_pc); end
    if (id_inst !== 32'h0) begin errors++; $display("[TB] FAIL rs_inst got %h want 0", id_inst); end
    if (hold_active !== 1'b0) begin errors++; $display("[TB] FAIL rs_hold got %0b want 0", hold_active); end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    stall           = 6'b0;
    flush           = 1'b0;
    if_to_id_bus    = 33'h0;
    inst_sram_rdata = 32'h0;
    test_reset();
    test_advance();
    test_ce_zero();
    test_id_stall();
    test_if_stall();
    test_flush_mid_stall();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline register between the IF stage and the ID decoder in the 5-stage MIPS core.
- Registers IF's {ce, pc} bus and aligns it with the instruction SRAM read data, which returns one cycle after the address.
- Protects the fetched instruction across stalls by capturing the SRAM data into a hold buffer, so ID always sees the instruction matching its PC.
- Inserts bubbles on stall boundaries and clears on flush.

Parameters:
- PC_W, 32, PC width.
- INST_W, 32, instruction word width.
- STALL_W, 6, stall bus width; bit 1 = IF stage, bit 2 = ID stage.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALL_W  stall vector from the stall controller; 1 = Stop.
- flush  in  1  exception/eret flush; kills the held instruction.
- if_to_id_bus  in  PC_W+1  {ce, pc} from IF.
- inst_sram_rdata  in  INST_W  instruction SRAM read data (1-cycle latency).
- id_valid  out  1  ID holds a real instruction.
- id_pc  out  PC_W  PC of the instruction in ID.
- id_inst  out  INST_W  instruction presented to the decoder.
- hold_active  out  1  id_inst is sourced from the hold buffer (debug/perf).

Behaviour:
- Reset: valid_r=0, pc_r=0, inst_hold=0, hold_valid=0. Outputs: id_valid=0, id_pc=0, id_inst=0, hold_active=0.
- Priority at each posedge: rst > flush > stall-driven update.
- flush=1: valid_r<=0, pc_r<=0, hold_valid<=0, inst_hold<=0, regardless of stall.
- stall[1]=0 (advance):
  - valid_r<=ce, pc_r<=pc.
  - hold_valid<=0.
- stall[1]=1 and stall[2]=0 (IF frozen, ID drains):
  - Insert a bubble: valid_r<=0, pc_r<=0, hold_valid<=0.
- stall[1]=1 and stall[2]=1 (both frozen):
  - valid_r and pc_r hold.
  - If hold_valid=0: inst_hold<=inst_sram_rdata, hold_valid<=1.
  - If hold_valid=1: inst_hold holds.
  - Reason: once IF is frozen, the SRAM address moves on to the next PC, so SRAM data no longer matches pc_r after the first stalled edge.
- id_inst (combinational):
  - 0 when valid_r=0.
  - else inst_hold when hold_valid=1.
  - else inst_sram_rdata.
- id_valid=valid_r, id_pc=pc_r, hold_active=hold_valid.
- Latency: a PC accepted at edge k appears on id_pc in cycle k+1, with its instruction in that same cycle.
- Multi-cycle stall: the value captured on the first stalled edge persists for any stall length. It is released on the edge where stall[1] returns to 0.
- Flush during a stall: buffer cleared, bubble output, no stale instruction after the stall releases.
- ce=0 from IF (first cycle after reset): valid_r=0, so id_inst=0 (NOP) even though the SRAM output is undefined.
- Illegal combination stall[1]=0 with stall[2]=1: treat as advance. Verification asserts it never occurs.

Decomposition:
- Shared defines header: StallBus range, Stop/NoStop, IF_TO_ID_WD, NOP encoding (32'h0).
- One natural sub-module, inst_hold_buf: capture/hold/select of the SRAM word.
  - Inputs: clk, rst, clear, capture, rdata.
  - Outputs: inst, hold_valid.
- The stage register and bubble logic stay in the top module.

Test Plan:
1. Reset release, no stall:
   - Stimulus: IF bus {1, 0xBFC00000}, then {1, 0xBFC00004}; SRAM returns 0x3C08BFC0, 0x35080010.
   - Response: id_pc/id_inst pairs match one cycle after each PC, id_valid=1.
2. Reset, ce=0:
   - Stimulus: IF bus {0, 0xBFBFFFFC}, SRAM rdata = 0xDEADBEEF.
   - Response: id_valid=0, id_inst=0.
3. ID stall for 3 cycles:
   - Stimulus: pc_r=0x80000010 with inst 0x8C220004; stall=6'b000111 for 3 cycles; SRAM switches to 0x00000000.
   - Response: id_inst stays 0x8C220004, hold_active=1 for 3 cycles, then next PC 0x80000014.
4. IF stall with ID free:
   - Stimulus: stall=6'b000011.
   - Response: next cycle id_valid=0, id_pc=0, id_inst=0; the PC is re-presented after release with no loss and no duplication.
5. Flush mid-stall:
   - Stimulus: hold_valid=1, flush=1 with stall=6'b000111.
   - Response: next cycle id_valid=0, hold_active=0; after release the first instruction comes from the new IF PC.
6. Reset mid-stall:
   - Stimulus: rst=1 while hold_valid=1.
   - Response: all outputs 0 on the next edge.
